// File: rtl/fp_branch_pkg.sv
// Shared definitions for the FP compare-and-branch resolver: op encodings, format split, canonical NaNs.
package fp_branch_pkg;

  localparam logic [2:0] OP_EQ = 3'b000;
  localparam logic [2:0] OP_NE = 3'b001;
  localparam logic [2:0] OP_LT = 3'b010;
  localparam logic [2:0] OP_GE = 3'b011;
  localparam logic [2:0] OP_LE = 3'b100;
  localparam logic [2:0] OP_GT = 3'b101;

  localparam logic [63:0] QNAN64 = 64'h7FF8_0000_0000_0000;
  localparam logic [31:0] QNAN32 = 32'h7FC0_0000;

  // Field split for the supported IEEE formats: 32 = single, anything else = double.
  function automatic int unsigned mantissa_size(input int unsigned bus_width);
    return (bus_width == 32) ? 23 : 52;
  endfunction

  function automatic int unsigned exponent_size(input int unsigned bus_width);
    return (bus_width == 32) ? 8 : 11;
  endfunction

endpackage

// File: rtl/fp_cmp_core.sv
// Combinational IEEE compare: equality, strict less-than, unordered and signalling-NaN detection.
module fp_cmp_core
  import fp_branch_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 64
) (
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  output logic                 eq,
  output logic                 lt,
  output logic                 unordered,
  output logic                 any_snan
);

  localparam int unsigned MW = mantissa_size(BUS_WIDTH);
  localparam int unsigned EW = exponent_size(BUS_WIDTH);

  logic          a_sign, b_sign;
  logic [EW-1:0] a_exp, b_exp;
  logic [MW-1:0] a_man, b_man;
  logic [BUS_WIDTH-2:0] a_mag, b_mag;
  logic          a_nan, b_nan, a_snan, b_snan, both_zero;

  assign a_sign = a[BUS_WIDTH-1];
  assign b_sign = b[BUS_WIDTH-1];
  assign a_exp  = a[BUS_WIDTH-2 -: EW];
  assign b_exp  = b[BUS_WIDTH-2 -: EW];
  assign a_man  = a[MW-1:0];
  assign b_man  = b[MW-1:0];
  assign a_mag  = a[BUS_WIDTH-2:0];
  assign b_mag  = b[BUS_WIDTH-2:0];

  assign a_nan  = (&a_exp) && (|a_man);
  assign b_nan  = (&b_exp) && (|b_man);
  assign a_snan = a_nan && !a_man[MW-1];
  assign b_snan = b_nan && !b_man[MW-1];
  assign both_zero = ~(|a_mag) && ~(|b_mag);

  // Sign-magnitude ordering; magnitudes compare reversed when both are negative.
  always_comb begin
    unordered = a_nan || b_nan;
    any_snan  = a_snan || b_snan;
    eq        = !unordered && (both_zero || (a == b));
    lt        = 1'b0;
    if (!unordered && !both_zero) begin
      if (a_sign != b_sign) lt = a_sign;
      else if (a_sign)      lt = a_mag > b_mag;
      else                  lt = a_mag < b_mag;
    end
  end

endmodule

// File: rtl/fp_branch_resolve.sv
// Two-stage FP compare-and-branch resolver with valid/ready flow control and flush.
module fp_branch_resolve
  import fp_branch_pkg::*;
#(
  parameter int unsigned BUS_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned IMM_WIDTH  = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BUS_WIDTH-1:0]  in1,
  input  logic [BUS_WIDTH-1:0]  in2,
  input  logic [2:0]            op,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [IMM_WIDTH-1:0]  imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  taken,
  output logic [ADDR_WIDTH-1:0] target,
  output logic                  flag_nv,
  output logic                  flag_ill
);

  logic                  s1_valid;
  logic [BUS_WIDTH-1:0]  s1_in1, s1_in2;
  logic [2:0]            s1_op;
  logic [ADDR_WIDTH-1:0] s1_pc;
  logic [IMM_WIDTH-1:0]  s1_imm;

  logic s2_move, s1_move;
  logic cmp_eq, cmp_lt, cmp_unordered, cmp_any_snan, cmp_gt;
  logic taken_c, nv_c, ill_c;
  logic [ADDR_WIDTH-1:0] target_c;

  assign s2_move  = !out_valid || out_ready;
  assign s1_move  = !s1_valid || s2_move;
  assign in_ready = s1_move && !flush && !rst;

  fp_cmp_core #(.BUS_WIDTH(BUS_WIDTH)) u_cmp (
    .a         (s1_in1),
    .b         (s1_in2),
    .eq        (cmp_eq),
    .lt        (cmp_lt),
    .unordered (cmp_unordered),
    .any_snan  (cmp_any_snan)
  );

  assign cmp_gt   = !cmp_lt && !cmp_eq && !cmp_unordered;
  assign target_c = s1_pc + {{(ADDR_WIDTH-IMM_WIDTH){s1_imm[IMM_WIDTH-1]}}, s1_imm};

  // Op decode: EQ/NE only trap on signalling NaNs, ordered compares trap on any NaN.
  always_comb begin
    taken_c = 1'b0;
    nv_c    = 1'b0;
    ill_c   = 1'b0;
    case (s1_op)
      OP_EQ: begin taken_c = cmp_eq;            nv_c = cmp_any_snan;  end
      OP_NE: begin taken_c = !cmp_eq;           nv_c = cmp_any_snan;  end
      OP_LT: begin taken_c = cmp_lt;            nv_c = cmp_unordered; end
      OP_GE: begin taken_c = cmp_gt || cmp_eq;  nv_c = cmp_unordered; end
      OP_LE: begin taken_c = cmp_lt || cmp_eq;  nv_c = cmp_unordered; end
      OP_GT: begin taken_c = cmp_gt;            nv_c = cmp_unordered; end
      default: ill_c = 1'b1;
    endcase
  end

  // Pipeline registers: reset beats flush, flush beats any handshake advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_in1    <= '0;
      s1_in2    <= '0;
      s1_op     <= '0;
      s1_pc     <= '0;
      s1_imm    <= '0;
      out_valid <= 1'b0;
      taken     <= 1'b0;
      target    <= '0;
      flag_nv   <= 1'b0;
      flag_ill  <= 1'b0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s1_move) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_in1 <= in1;
          s1_in2 <= in2;
          s1_op  <= op;
          s1_pc  <= pc;
          s1_imm <= imm;
        end
      end
      if (s2_move) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          taken    <= taken_c;
          target   <= target_c;
          flag_nv  <= nv_c;
          flag_ill <= ill_c;
        end
      end
    end
  end

endmodule
